// File: rtl/wb_ifetch_pkg.sv
// wb_ifetch_pkg: shared types and sizing helper for the J1 instruction prefetch unit
package wb_ifetch_pkg;

    localparam int IF_AW = 12;
    localparam int IF_DW = 16;

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [IF_AW-1:0] adr;
        logic [IF_DW-1:0] dat;
    } entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_ifetch_if.sv
// wb_ifetch_if: Wishbone fetch bus plus core-side instruction port of wb_ifetch
interface wb_ifetch_if
    import wb_ifetch_pkg::*;
#(
    parameter int AW = IF_AW,
    parameter int DW = IF_DW
);
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_stall_i;
    logic          fetch_en_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_adr_i;
    logic [DW-1:0] insn_o;
    logic [AW-1:0] insn_adr_o;
    logic          insn_valid_o;
    logic          insn_ready_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_adr_o, insn_o, insn_adr_o, insn_valid_o,
        input  wb_dat_i, wb_ack_i, wb_stall_i, fetch_en_i, redirect_i, redirect_adr_i, insn_ready_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_adr_o, insn_o, insn_adr_o, insn_valid_o,
        output wb_dat_i, wb_ack_i, wb_stall_i, fetch_en_i, redirect_i, redirect_adr_i, insn_ready_i
    );

endinterface

// File: rtl/wb_ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry show-ahead queue of fetched words with synchronous clear
module ifetch_fifo
    import wb_ifetch_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clr,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  entry_t                    i_dat,
    output entry_t                    o_dat,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_dat;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dat   = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

// File: rtl/wb_ifetch.sv
// wb_ifetch: pipelined Wishbone instruction prefetcher with branch flush for the J1 core.
// WB_IFETCH_CYC_DROP_EN: wb_cyc_o drops when idle; otherwise it is held high after reset.
module wb_ifetch
    import wb_ifetch_pkg::*;
#(
    parameter int            AW         = IF_AW,
    parameter int            DW         = IF_DW,
    parameter int            DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
)(
    input logic         clk,
    input logic         rst_n,
    wb_ifetch_if.master bus
);

    localparam int CW = cnt_w(DEPTH);

    state_t        r_state;
    logic [AW-1:0] r_fadr;
    logic [AW-1:0] r_aadr;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;
    logic          r_live;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_out_nxt;
    logic          w_stb;
    logic          w_acc;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    entry_t        w_wr;
    entry_t        w_head;

    // queued plus in-flight words never exceed DEPTH, so every ack has a slot
    assign w_stb     = r_live && r_state == RUN && bus.fetch_en_i &&
                       ({1'b0, w_cnt} + {1'b0, r_out} < (CW+1)'(DEPTH));
    assign w_acc     = w_stb && !bus.wb_stall_i;
    assign w_ack     = bus.wb_ack_i && r_out != '0;
    assign w_out_nxt = r_out + CW'(w_acc) - CW'(w_ack);
    assign w_push    = w_ack && r_state == RUN && !bus.redirect_i;
    assign w_pop     = w_cnt != '0 && bus.insn_ready_i && !bus.redirect_i;
    assign w_wr      = '{adr: r_aadr, dat: bus.wb_dat_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_fadr  <= RESET_ADDR;
            r_aadr  <= RESET_ADDR;
            r_out   <= '0;
            r_disc  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_out  <= w_out_nxt;
            if (bus.redirect_i) begin
                r_fadr  <= bus.redirect_adr_i;
                r_aadr  <= bus.redirect_adr_i;
                r_disc  <= w_out_nxt;
                r_state <= (w_out_nxt != '0) ? FLUSH : RUN;
            end else begin
                if (w_acc) r_fadr <= r_fadr + 1'b1;
                if (w_push) r_aadr <= r_aadr + 1'b1;
                if (r_state == FLUSH && w_ack) begin
                    r_disc <= r_disc - 1'b1;
                    if (r_disc == CW'(1)) r_state <= RUN;
                end
            end
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (bus.redirect_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (w_wr),
        .o_dat   (w_head),
        .o_count (w_cnt)
    );

    assign bus.wb_stb_o     = w_stb;
    assign bus.wb_adr_o     = r_fadr;
`ifdef WB_IFETCH_CYC_DROP_EN
    assign bus.wb_cyc_o     = w_stb || r_out != '0;
`else
    assign bus.wb_cyc_o     = r_live;
`endif
    assign bus.insn_o       = w_head.dat;
    assign bus.insn_adr_o   = w_head.adr;
    assign bus.insn_valid_o = w_cnt != '0;

    a_no_stray_ack: assert property (@(posedge clk) disable iff (!rst_n) !(bus.wb_ack_i && r_out == '0));

endmodule

// File: tb/tb_wb_ifetch.sv
// tb_wb_ifetch: randomized bench checking wb_ifetch against a stream-level fetch model
module tb_wb_ifetch;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_ifetch_if #(.AW(AW), .DW(DW)) bus();

    wb_ifetch #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_ADDR(12'h000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_pass = 0;
    int            acc_cnt = 0;
    int            pops = 0;
    int            stall_prob = 0;
    int            ack_prob = 100;
    logic [AW-1:0] q[$];
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] next_issue = '0;
    logic [AW-1:0] hold_adr = '0;
    logic          exp_empty = 1'b0;
    logic          hold_chk = 1'b0;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return {a[3:0], a} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // sequential program-order model: issued addresses, consumed stream, outstanding reads
    task automatic observe();
        if (q.size() != 0 || bus.wb_stb_o) check("cyc_busy", 32'(bus.wb_cyc_o), 1);
        if (exp_empty) check("flush_empty", 32'(bus.insn_valid_o), 0);
        if (hold_chk) check("stall_hold", 32'(bus.wb_adr_o), 32'(hold_adr));
        hold_chk = bus.wb_stb_o && bus.wb_stall_i && !bus.redirect_i;
        hold_adr = bus.wb_adr_o;
        if (bus.wb_ack_i) void'(q.pop_front());
        if (bus.wb_stb_o && !bus.wb_stall_i) begin
            check("issue_adr", 32'(bus.wb_adr_o), 32'(next_issue));
            next_issue++;
            acc_cnt++;
            q.push_back(bus.wb_adr_o);
            check("credit", 32'(q.size() <= DEPTH), 1);
        end
        if (bus.insn_valid_o && bus.insn_ready_i && !bus.redirect_i) begin
            check("insn_adr", 32'(bus.insn_adr_o), 32'(pc));
            check("insn_dat", 32'(bus.insn_o), 32'(rom(pc)));
            pc++;
            pops++;
        end
        exp_empty = bus.redirect_i;
        if (bus.redirect_i) begin
            pc = bus.redirect_adr_i;
            next_issue = bus.redirect_adr_i;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        bus.wb_stall_i = $urandom_range(99) < stall_prob;
        bus.wb_ack_i = q.size() != 0 && $urandom_range(99) < ack_prob;
        if (bus.wb_ack_i) bus.wb_dat_i = rom(q[0]);
        else bus.wb_dat_i = DW'($urandom);
    endtask

    initial begin
        int n;
        int a0;
        bus.wb_dat_i = '0;
        bus.wb_ack_i = 1'b0;
        bus.wb_stall_i = 1'b0;
        bus.fetch_en_i = 1'b1;
        bus.redirect_i = 1'b0;
        bus.redirect_adr_i = '0;
        bus.insn_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", 32'(bus.wb_cyc_o), 0);
        check("rst_stb", 32'(bus.wb_stb_o), 0);
        check("rst_adr", 32'(bus.wb_adr_o), 0);
        check("rst_valid", 32'(bus.insn_valid_o), 0);
        check("rst_insn", 32'(bus.insn_o), 0);
        check("rst_insn_adr", 32'(bus.insn_adr_o), 0);
        rst_n = 1'b1;

        n = 0;
        while (!bus.insn_valid_o && n < 10) begin tick(); n++; end
        check("first_valid_tmo", 32'(n < 10), 1);
        check("first_insn_adr", 32'(bus.insn_adr_o), 0);
        repeat (8) begin tick(); check("stream_valid", 32'(bus.insn_valid_o), 1); end

        bus.fetch_en_i = 1'b0;
        n = 0;
        while ((q.size() != 0 || bus.insn_valid_o) && n < 30) begin tick(); n++; end
        check("drain_tmo", 32'(n < 30), 1);
        bus.insn_ready_i = 1'b0;
        bus.fetch_en_i = 1'b1;
        a0 = acc_cnt;
        repeat (12) tick();
        check("full_reqs", 32'(acc_cnt - a0), 4);
        check("full_stb", 32'(bus.wb_stb_o), 0);
        bus.insn_ready_i = 1'b1;
        tick();
        bus.insn_ready_i = 1'b0;
        repeat (6) tick();
        check("one_more_req", 32'(acc_cnt - a0), 5);

        ack_prob = 0;
        bus.insn_ready_i = 1'b1;
        n = 0;
        while (q.size() != 2 && n < 20) begin tick(); n++; end
        check("out2_tmo", 32'(n < 20), 1);
        bus.fetch_en_i = 1'b0;
        bus.redirect_i = 1'b1;
        bus.redirect_adr_i = 12'h100;
        tick();
        bus.redirect_i = 1'b0;
        bus.fetch_en_i = 1'b1;
        ack_prob = 100;
        #1;
        check("flush_stb", 32'(bus.wb_stb_o), 0);
        n = 0;
        while (!bus.insn_valid_o && n < 20) begin tick(); n++; end
        check("redir_tmo", 32'(n < 20), 1);
        check("redir_insn_adr", 32'(bus.insn_adr_o), 32'h100);
        check("redir_insn_dat", 32'(bus.insn_o), 32'(rom(12'h100)));

        bus.fetch_en_i = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 20) begin tick(); n++; end
        check("idle_tmo", 32'(n < 20), 1);
        bus.redirect_i = 1'b1;
        bus.redirect_adr_i = 12'hFFE;
        tick();
        bus.redirect_i = 1'b0;
        bus.fetch_en_i = 1'b1;
        #1;
        check("pen_stb1", 32'(bus.wb_stb_o), 1);
        check("pen_adr1", 32'(bus.wb_adr_o), 32'hFFE);
        check("pen_valid1", 32'(bus.insn_valid_o), 0);
        tick();
        check("pen_adr2", 32'(bus.wb_adr_o), 32'hFFF);
        check("pen_valid2", 32'(bus.insn_valid_o), 0);
        tick();
        check("pen_valid3", 32'(bus.insn_valid_o), 1);
        check("pen_insn_adr3", 32'(bus.insn_adr_o), 32'hFFE);
        repeat (6) tick();

        check("coinc_pre", 32'(bus.insn_valid_o && bus.wb_ack_i), 1);
        bus.redirect_i = 1'b1;
        bus.redirect_adr_i = 12'h234;
        tick();
        bus.redirect_i = 1'b0;
        check("coinc_empty", 32'(bus.insn_valid_o), 0);
        repeat (10) tick();

        stall_prob = 50;
        ack_prob = 60;
        repeat (300) tick();

        for (int b = 0; b < 6; b++) begin
            stall_prob = int'($urandom_range(60));
            ack_prob = 30 + int'($urandom_range(70));
            repeat (500) begin
                bus.fetch_en_i = $urandom_range(9) != 0;
                bus.insn_ready_i = $urandom_range(3) != 0;
                bus.redirect_i = $urandom_range(29) == 0;
                bus.redirect_adr_i = AW'($urandom);
                tick();
            end
        end

        bus.redirect_i = 1'b0;
        bus.fetch_en_i = 1'b1;
        bus.insn_ready_i = 1'b1;
        stall_prob = 0;
        ack_prob = 100;
        a0 = pops;
        repeat (30) tick();
        check("liveness", 32'(pops - a0 >= 20), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_ifetch.md
# wb_ifetch

Instruction prefetch unit for the J1 core. It is a classic-pipelined Wishbone master sitting directly upstream of the instruction ROM. It streams sequential 16-bit words from a fetch address into a small show-ahead queue for the core. On a branch redirect it flushes the queue and discards in-flight acknowledges.

## Interface
Parameters:
- AW, 12, word-address width (ROM of 2^AW words)
- DW, 16, instruction/data width
- DEPTH, 4, queue depth; also the maximum of queued plus outstanding words (power of two, ≥2)
- RESET_ADDR, 0, fetch address after reset

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  request strobe
- wb_adr_o  out  AW  word address
- wb_dat_i  in  DW  read data, valid with ack
- wb_ack_i  in  1  acknowledge
- wb_stall_i  in  1  slave stall
- fetch_en_i  in  1  permit new requests
- redirect_i  in  1  one-cycle branch pulse
- redirect_adr_i  in  AW  branch target
- insn_o  out  DW  head-of-queue instruction
- insn_adr_o  out  AW  address of insn_o
- insn_valid_o  out  1  queue non-empty
- insn_ready_i  in  1  core consumes head when valid

## Operation
- Reset: state RUN, fetch address = RESET_ADDR, queue empty, outstanding = 0, discard = 0.
- All outputs are 0 during reset, except wb_adr_o = RESET_ADDR.
- Request issue: wb_stb_o = RUN & fetch_en_i & (count + outstanding < DEPTH), using registered values.
- Acceptance: a request is accepted when wb_stb_o & ~wb_stall_i. On acceptance:
  - outstanding increments.
  - fetch address increments modulo 2^AW (0xFFF wraps to 0x000 for AW=12).
- Ack handling: outstanding decrements on every wb_ack_i.
  - In RUN, {wb_dat_i, address} is written to the queue.
  - In FLUSH, the ack is dropped and discard decrements.
- Address tracking: a second counter, the ack address, follows accepted addresses for insn_adr_o.
- Simultaneous accept and ack leave outstanding unchanged.
- Consumption: insn_valid_o & insn_ready_i pops the head.
- Redirect (highest priority):
  - The queue is cleared and any same-cycle pop or push is ignored.
  - Fetch address and ack address are set to redirect_adr_i.
  - discard = outstanding value after this cycle's accept and ack.
  - Next state is FLUSH if discard ≠ 0, else RUN.
- A redirect during FLUSH updates the target only; discard keeps counting the same in-flight acks.
- FLUSH → RUN when discard reaches 0 on an ack.
- wb_cyc_o is held high while outstanding ≠ 0 or wb_stb_o is high. It never drops with acks pending.
- fetch_en_i low blocks only new requests; outstanding acks still complete into the queue.
- Acks arriving with outstanding = 0 are a protocol error. They are ignored and a simulation assertion fires.

## Timing
- Zero-wait slave, redirect in cycle N: wb_stb_o in N+1, ack in N+2, insn_valid_o in N+3 (3-cycle redirect penalty).
- Steady state throughput is one word per cycle when insn_ready_i is held high.
- Queue is registered and show-ahead: push at edge E makes insn_valid_o high after E. No combinational path from wb_ack_i to insn_valid_o.
- wb_stb_o and wb_adr_o are held stable while wb_stall_i is high.

## Configuration
- WB_IFETCH_CYC_DROP_EN:
  - Defined: wb_cyc_o is combinational as described above and drops when idle.
  - Undefined: wb_cyc_o is a register set at the first cycle after reset and held high permanently. This minimises logic for a single-master ROM bus.
- Request and queue behaviour is identical in both builds.

## Structure
- Package wb_ifetch_pkg holds:
  - state enum {RUN, FLUSH}
  - queue entry struct {adr, dat}
  - function returning the count width $clog2(DEPTH+1)
- Sub-module ifetch_fifo: DEPTH-entry show-ahead FIFO with clear, push, pop, count, async active-low reset. Pointers wrap modulo DEPTH. Simultaneous push and pop when full is legal.

## Test plan
- Reset release, zero-wait ROM containing its own address at each word → first wb_adr_o = 0x000; insn_o sequence 0x000, 0x001, 0x002… at one per cycle.
- insn_ready_i held low → exactly 4 requests issued, then wb_stb_o low; one pop → exactly one further request.
- Redirect to 0x100 with 2 requests outstanding → both acks discarded, next wb_adr_o = 0x100, first insn_adr_o = 0x100.
- Redirect to 0xFFE → fetch addresses 0xFFE, 0xFFF, 0x000, 0x001; insn_adr_o follows the wrap.
- Slave with 2 wait cycles (stall) → wb_adr_o held across stalls; no duplicated or skipped words.
- Redirect coincident with a pop and an ack → queue empty next cycle; the ack is counted as discarded only if issued before the redirect.
